// File: rtl/muldiv_unit_pkg.sv
// Shared types and constants for the HI/LO multiply/divide unit.
// The funct decode maps MIPS SPECIAL funct codes onto unit operations.
package muldiv_unit_pkg;

  localparam int DATA_W    = 32;
  localparam int DIV_ITERS = 32;
  localparam int CNT_W     = 6;

  typedef enum logic [2:0] {
    MD_MULT  = 3'd0,
    MD_MULTU = 3'd1,
    MD_DIV   = 3'd2,
    MD_DIVU  = 3'd3,
    MD_MTHI  = 3'd4,
    MD_MTLO  = 3'd5,
    MD_NONE  = 3'd7
  } muldiv_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2
  } md_state_t;

  function automatic muldiv_op_t decode_funct(input logic [5:0] funct);
    muldiv_op_t op_v;
    case (funct)
      6'h18:   op_v = MD_MULT;
      6'h19:   op_v = MD_MULTU;
      6'h1A:   op_v = MD_DIV;
      6'h1B:   op_v = MD_DIVU;
      6'h11:   op_v = MD_MTHI;
      6'h13:   op_v = MD_MTLO;
      default: op_v = MD_NONE;
    endcase
    return op_v;
  endfunction

endpackage

// File: rtl/muldiv_unit_if.sv
// Issue/result bundle between the EX stage and the multiply/divide unit.
interface muldiv_unit_if;
  import muldiv_unit_pkg::*;

  logic              start;
  muldiv_op_t        op;
  logic [DATA_W-1:0] src_a;
  logic [DATA_W-1:0] src_b;
  logic              flush;
  logic              busy;
  logic              done;
  logic [DATA_W-1:0] hi;
  logic [DATA_W-1:0] lo;

  modport master (output start, op, src_a, src_b, flush,
                  input  busy, done, hi, lo);
  modport slave  (input  start, op, src_a, src_b, flush,
                  output busy, done, hi, lo);

endinterface

// File: rtl/muldiv_unit_chk.sv
// Protocol checker: a new operation must never be issued while the unit is busy.
module muldiv_unit_chk (
  input logic clk,
  input logic rst_n,
  input logic en,
  input logic start,
  input logic busy
);

  a_no_start_while_busy: assert property (
    @(posedge clk) disable iff (!rst_n) (en && start) |-> !busy
  ) else $error("start issued while muldiv_unit busy");

endmodule

// File: rtl/muldiv_unit_divider.sv
// Unsigned restoring radix-2 divider core; the parent sequences load/step
// and owns all sign handling.
module restoring_divider
  import muldiv_unit_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              step,
  input  logic [DATA_W-1:0] dividend,
  input  logic [DATA_W-1:0] divisor,
  output logic [DATA_W-1:0] quotient,
  output logic [DATA_W-1:0] remainder
);

  logic [DATA_W-1:0] rem_r;
  logic [DATA_W-1:0] quo_r;
  logic [DATA_W-1:0] dsr_r;
  logic [DATA_W:0]   shifted_s;
  logic [DATA_W:0]   diff_s;

  // Trial subtraction of the divisor from the partial remainder shifted left by one.
  always_comb begin
    shifted_s = {rem_r, quo_r[DATA_W-1]};
    diff_s    = shifted_s - {1'b0, dsr_r};
  end

  // Quotient bits shift in at the bottom while dividend bits shift out the top.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem_r <= {DATA_W{1'b0}};
      quo_r <= {DATA_W{1'b0}};
      dsr_r <= {DATA_W{1'b0}};
    end else if (load) begin
      rem_r <= {DATA_W{1'b0}};
      quo_r <= dividend;
      dsr_r <= divisor;
    end else if (step) begin
      if (!diff_s[DATA_W]) begin
        rem_r <= diff_s[DATA_W-1:0];
        quo_r <= {quo_r[DATA_W-2:0], 1'b1};
      end else begin
        rem_r <= shifted_s[DATA_W-1:0];
        quo_r <= {quo_r[DATA_W-2:0], 1'b0};
      end
    end else begin
      rem_r <= rem_r;
    end
  end

  assign quotient  = quo_r;
  assign remainder = rem_r;

endmodule

// File: rtl/muldiv_unit.sv
// Iterative HI/LO multiply/divide unit: fixed-latency multiply, 33-cycle
// restoring divide, MTHI/MTLO writes, and a busy flag for stall control.
module muldiv_unit
  import muldiv_unit_pkg::*;
#(
  parameter int MUL_LATENCY = 3
) (
  input logic          clk,
  input logic          rst_n,
  muldiv_unit_if.slave bus
);

  localparam logic [CNT_W-1:0] MUL_INIT = CNT_W'(MUL_LATENCY - 1);

  md_state_t         state_r, state_nxt_s;
  logic [CNT_W-1:0]  cnt_r, cnt_nxt_s;
  logic              accept_s, finish_s, step_s;
  logic [63:0]       prod_r, product_s;
  logic              sgn_s;
  logic [DATA_W-1:0] abs_a_s, abs_b_s, quo_s, rem_s;
  logic              neg_q_r, neg_r_r, div_zero_r;
  logic [DATA_W-1:0] a_lat_r, hi_r, lo_r;
  logic              busy_r, done_r;

  // Operand conditioning: sign-extend for the product, magnitudes for the divider.
  always_comb begin
    sgn_s     = (bus.op == MD_MULT) || (bus.op == MD_DIV);
    product_s = {{DATA_W{sgn_s & bus.src_a[DATA_W-1]}}, bus.src_a}
              * {{DATA_W{sgn_s & bus.src_b[DATA_W-1]}}, bus.src_b};
    abs_a_s   = (sgn_s && bus.src_a[DATA_W-1]) ? (~bus.src_a + 32'd1) : bus.src_a;
    abs_b_s   = (sgn_s && bus.src_b[DATA_W-1]) ? (~bus.src_b + 32'd1) : bus.src_b;
  end

  // Next-state logic; flush always wins over completion.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    accept_s    = 1'b0;
    finish_s    = 1'b0;
    step_s      = 1'b0;
    case (state_r)
      IDLE: begin
        if (bus.start && !bus.flush) begin
          accept_s = 1'b1;
          case (bus.op)
            MD_MULT, MD_MULTU: begin
              state_nxt_s = MUL;
              cnt_nxt_s   = MUL_INIT;
            end
            MD_DIV, MD_DIVU: begin
              state_nxt_s = DIV;
              cnt_nxt_s   = CNT_W'(DIV_ITERS);
            end
            default: state_nxt_s = IDLE;
          endcase
        end else begin
          state_nxt_s = IDLE;
        end
      end
      MUL, DIV: begin
        if (bus.flush) begin
          state_nxt_s = IDLE;
          cnt_nxt_s   = {CNT_W{1'b0}};
        end else if (cnt_r == {CNT_W{1'b0}}) begin
          state_nxt_s = IDLE;
          finish_s    = 1'b1;
        end else begin
          step_s    = (state_r == DIV);
          cnt_nxt_s = cnt_r - CNT_W'(1);
        end
      end
      default: begin
        state_nxt_s = IDLE;
        cnt_nxt_s   = {CNT_W{1'b0}};
      end
    endcase
  end

  // State and iteration counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      cnt_r   <= {CNT_W{1'b0}};
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
    end
  end

  restoring_divider u_div (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (accept_s && (bus.op == MD_DIV || bus.op == MD_DIVU)),
    .step      (step_s),
    .dividend  (abs_a_s),
    .divisor   (abs_b_s),
    .quotient  (quo_s),
    .remainder (rem_s)
  );

  // Operand capture at acceptance and HI/LO write-back at completion.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prod_r     <= 64'd0;
      neg_q_r    <= 1'b0;
      neg_r_r    <= 1'b0;
      div_zero_r <= 1'b0;
      a_lat_r    <= {DATA_W{1'b0}};
      hi_r       <= {DATA_W{1'b0}};
      lo_r       <= {DATA_W{1'b0}};
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
    end else begin
      busy_r <= (state_nxt_s != IDLE);
      done_r <= finish_s;
      if (accept_s) begin
        case (bus.op)
          MD_MULT, MD_MULTU: prod_r <= product_s;
          MD_DIV, MD_DIVU: begin
            neg_q_r    <= sgn_s && (bus.src_a[DATA_W-1] ^ bus.src_b[DATA_W-1]);
            neg_r_r    <= sgn_s && bus.src_a[DATA_W-1];
            div_zero_r <= (bus.src_b == {DATA_W{1'b0}});
            a_lat_r    <= bus.src_a;
          end
          MD_MTHI: hi_r <= bus.src_a;
          MD_MTLO: lo_r <= bus.src_a;
          default: prod_r <= prod_r;
        endcase
      end else if (finish_s && state_r == MUL) begin
        {hi_r, lo_r} <= prod_r;
      end else if (finish_s && state_r == DIV) begin
        if (div_zero_r) begin
          hi_r <= a_lat_r;
          lo_r <= {DATA_W{1'b1}};
        end else begin
          hi_r <= neg_r_r ? (~rem_s + 32'd1) : rem_s;
          lo_r <= neg_q_r ? (~quo_s + 32'd1) : quo_s;
        end
      end else begin
        hi_r <= hi_r;
      end
    end
  end

  assign bus.busy = busy_r;
  assign bus.done = done_r;
  assign bus.hi   = hi_r;
  assign bus.lo   = lo_r;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit with hand-computed vectors.
module tb_muldiv_unit;
  import muldiv_unit_pkg::*;

  logic clk;
  logic rst_n;
  logic chk_en;
  int   vectors;
  int   miscompares;
  int   n;

  muldiv_unit_if bus();

  muldiv_unit #(.MUL_LATENCY(3)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  muldiv_unit_chk u_chk (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (chk_en),
    .start (bus.start),
    .busy  (bus.busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Issue one op for a single cycle.
  task automatic issue(input muldiv_op_t op, input logic [31:0] a, input logic [31:0] b);
    bus.start = 1'b1;
    bus.op    = op;
    bus.src_a = a;
    bus.src_b = b;
    tick();
    bus.start = 1'b0;
  endtask

  // Count busy cycles after the accepting edge (bounded), then check done pulse.
  task automatic wait_idle(input string tag, input int exp_cycles);
    n = 0;
    while (bus.busy && n < 200) begin
      n++;
      tick();
    end
    chk({tag, "_busy_cycles"}, 32'(n), 32'(exp_cycles));
    chk({tag, "_done"}, {31'd0, bus.done}, 32'd1);
    tick();
    chk({tag, "_done_clear"}, {31'd0, bus.done}, 32'd0);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    chk_en      = 1'b1;
    rst_n       = 1'b0;
    bus.start   = 1'b0;
    bus.op      = MD_MULT;
    bus.src_a   = 32'd0;
    bus.src_b   = 32'd0;
    bus.flush   = 1'b0;

    #2;
    chk("rst_busy", {31'd0, bus.busy}, 32'd0);
    chk("rst_done", {31'd0, bus.done}, 32'd0);
    chk("rst_hi", bus.hi, 32'd0);
    chk("rst_lo", bus.lo, 32'd0);
    #10 rst_n = 1'b1;
    tick();

    issue(MD_MULT, 32'hFFFF_FFFD, 32'd5);
    wait_idle("mult", 3);
    chk("mult_hi", bus.hi, 32'hFFFF_FFFF);
    chk("mult_lo", bus.lo, 32'hFFFF_FFF1);

    issue(MD_MULTU, 32'hFFFF_FFFD, 32'd5);
    wait_idle("multu", 3);
    chk("multu_hi", bus.hi, 32'h0000_0004);
    chk("multu_lo", bus.lo, 32'hFFFF_FFF1);

    issue(MD_DIVU, 32'd100, 32'd7);
    wait_idle("divu", 33);
    chk("divu_lo", bus.lo, 32'd14);
    chk("divu_hi", bus.hi, 32'd2);

    issue(MD_DIV, 32'hFFFF_FFF9, 32'd2);
    wait_idle("div_neg", 33);
    chk("div_neg_lo", bus.lo, 32'hFFFF_FFFD);
    chk("div_neg_hi", bus.hi, 32'hFFFF_FFFF);

    issue(MD_DIV, 32'h0000_1234, 32'd0);
    wait_idle("div0", 33);
    chk("div0_lo", bus.lo, 32'hFFFF_FFFF);
    chk("div0_hi", bus.hi, 32'h0000_1234);

    issue(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_idle("ovf", 33);
    chk("ovf_lo", bus.lo, 32'h8000_0000);
    chk("ovf_hi", bus.hi, 32'd0);

    issue(MD_MTHI, 32'hDEAD_BEEF, 32'd0);
    chk("mthi_hi", bus.hi, 32'hDEAD_BEEF);
    chk("mthi_busy", {31'd0, bus.busy}, 32'd0);
    chk("mthi_done", {31'd0, bus.done}, 32'd0);

    // Start with flush in the same cycle must be dropped, MTHI included.
    bus.flush = 1'b1;
    issue(MD_MTHI, 32'h0BAD_0BAD, 32'd0);
    bus.flush = 1'b0;
    chk("flush_mthi_hi", bus.hi, 32'hDEAD_BEEF);

    // MTLO while a divide runs is ignored; operands changing later are ignored too.
    issue(MD_DIVU, 32'd100, 32'd7);
    bus.src_a = 32'd5;
    bus.src_b = 32'd1;
    repeat (4) tick();
    chk_en    = 1'b0;
    bus.start = 1'b1;
    bus.op    = MD_MTLO;
    bus.src_a = 32'h0000_0BAD;
    tick();
    bus.start = 1'b0;
    chk_en    = 1'b1;
    chk("intrude_busy", {31'd0, bus.busy}, 32'd1);
    wait_idle("intrude", 28);
    chk("intrude_lo", bus.lo, 32'd14);
    chk("intrude_hi", bus.hi, 32'd2);

    issue(MD_MTHI, 32'h11, 32'd0);
    issue(MD_MTLO, 32'h11, 32'd0);
    issue(MD_DIV, 32'd1000, 32'd3);
    repeat (9) tick();
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    chk("flush_busy", {31'd0, bus.busy}, 32'd0);
    chk("flush_done", {31'd0, bus.done}, 32'd0);
    chk("flush_hi", bus.hi, 32'h11);
    chk("flush_lo", bus.lo, 32'h11);
    issue(MD_MULT, 32'd2, 32'd3);
    wait_idle("post_flush", 3);
    chk("post_flush_lo", bus.lo, 32'd6);
    chk("post_flush_hi", bus.hi, 32'd0);

    // Reset asserted between clock edges mid-divide.
    issue(MD_MTHI, 32'h55, 32'd0);
    issue(MD_DIVU, 32'd100, 32'd7);
    repeat (19) tick();
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_hi", bus.hi, 32'd0);
    chk("async_rst_lo", bus.lo, 32'd0);
    chk("async_rst_busy", {31'd0, bus.busy}, 32'd0);
    #2 rst_n = 1'b1;
    tick();
    issue(MD_DIVU, 32'd9, 32'd3);
    wait_idle("post_rst", 33);
    chk("post_rst_lo", bus.lo, 32'd3);
    chk("post_rst_hi", bus.hi, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
